// File: rtl/add_sequencer.sv
// ---------------------------------------------------------------------------
// add_sequencer
//   Two-operand load-and-add sequencer.
//   - The first load strobe captures operand A.
//   - The second load strobe captures operand B.
//   - One ADD cycle registers the sum, the unsigned carry and the signed
//     overflow.
//   - The SHOW state then holds the result until the next load.
//
//   Build option:
//     ADD_SEQUENCER_ACCUM_EN - when defined, a load in SHOW starts a running
//                              total: A takes the current sum and B takes din.
//                              When undefined, a load in SHOW starts a fresh
//                              operand pair, and no accumulate path is built.
//
//   Resets:
//     reset - asynchronous, active-low.
//     clear - synchronous, active-high. clear wins over load.
// ---------------------------------------------------------------------------
module add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             ovf_out,
  output logic [1:0]       state_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GOT_A = 2'b01,
    ST_ADD   = 2'b10,
    ST_SHOW  = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;

  // Next values for the result registers. They are only committed in ADD.
  logic [WIDTH:0]   add_full_d;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             ovf_d;

  // Two's-complement overflow: both operands have the same sign, and the
  // sign of the result differs from it.
  function automatic logic calc_ovf(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Widened adder. Bit WIDTH is the unsigned carry; the low bits wrap.
  always_comb begin
    add_full_d = {1'b0, a_q} + {1'b0, b_q};
    sum_d      = add_full_d[WIDTH-1:0];
    carry_d    = add_full_d[WIDTH];
    ovf_d      = calc_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_d[WIDTH-1]);
  end

  // Sequencer FSM and all datapath registers. Reset and clear both return
  // to IDLE with every register zeroed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            a_q     <= din;
            b_q     <= {WIDTH{1'b0}};
            state_q <= ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (load) begin
            b_q     <= din;
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          // A load strobe arriving in this state is deliberately ignored.
          sum_q   <= sum_d;
          carry_q <= carry_d;
          ovf_q   <= ovf_d;
          state_q <= ST_SHOW;
        end
        ST_SHOW: begin
          if (load) begin
`ifdef ADD_SEQUENCER_ACCUM_EN
            // Running total: the held sum becomes the next A operand.
            a_q     <= sum_q;
            b_q     <= din;
            state_q <= ST_ADD;
`else
            // Fresh operand pair. The previous result stays visible until
            // the next ADD overwrites it.
            a_q     <= din;
            b_q     <= {WIDTH{1'b0}};
            state_q <= ST_GOT_A;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // busy and done are status decodes of the state register alone, so they
  // never follow input activity.
  always_comb begin
    busy = (state_q == ST_ADD);
    done = (state_q == ST_SHOW);
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign sum_out   = sum_q;
  assign carry_out = carry_q;
  assign ovf_out   = ovf_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_add_sequencer
//   Self-checking bench for add_sequencer.
//   - Runs directed scenarios first, then randomized load/clear/reset
//     traffic.
//   - A transaction-level reference model built from the sequencing rules
//     predicts every output after every cycle.
//   - Define ADD_SEQUENCER_ACCUM_EN for both this bench and the RTL to check
//     accumulate mode.
// ---------------------------------------------------------------------------
module tb_add_sequencer;

  localparam int W       = 8;
  localparam int MOD     = 1 << W;
  localparam int SMAX    = (1 << (W - 1)) - 1;
  localparam int SMIN    = -(1 << (W - 1));
  localparam int M_IDLE  = 0;
  localparam int M_GOT_A = 1;
  localparam int M_ADD   = 2;
  localparam int M_SHOW  = 3;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         ovf_out;
  logic [1:0]   state_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, kept as plain integers.
  int m_st;
  int m_a;
  int m_b;
  int m_sum;
  int m_carry;
  int m_ovf;

  add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .load      (load),
    .din       (din),
    .a_out     (a_out),
    .b_out     (b_out),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .ovf_out   (ovf_out),
    .state_out (state_out),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp,
               $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  task automatic model_reset();
    m_st    = M_IDLE;
    m_a     = 0;
    m_b     = 0;
    m_sum   = 0;
    m_carry = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input bit clr, input bit ld, input int d);
    int total;
    int stotal;
    if (clr) begin
      model_reset();
    end else begin
      case (m_st)
        M_IDLE:  if (ld) begin m_a = d; m_b = 0; m_st = M_GOT_A; end
        M_GOT_A: if (ld) begin m_b = d; m_st = M_ADD; end
        M_ADD: begin
          total   = m_a + m_b;
          stotal  = to_signed(m_a) + to_signed(m_b);
          m_sum   = total % MOD;
          m_carry = (total >= MOD) ? 1 : 0;
          m_ovf   = (stotal > SMAX || stotal < SMIN) ? 1 : 0;
          m_st    = M_SHOW;
        end
        default: begin
          if (ld) begin
`ifdef ADD_SEQUENCER_ACCUM_EN
            m_a  = m_sum;
            m_b  = d;
            m_st = M_ADD;
`else
            m_a  = d;
            m_b  = 0;
            m_st = M_GOT_A;
`endif
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("a_out",     32'(a_out),     32'(m_a));
    check_eq("b_out",     32'(b_out),     32'(m_b));
    check_eq("sum_out",   32'(sum_out),   32'(m_sum));
    check_eq("carry_out", 32'(carry_out), 32'(m_carry));
    check_eq("ovf_out",   32'(ovf_out),   32'(m_ovf));
    check_eq("state_out", 32'(state_out), 32'(m_st));
    check_eq("busy",      32'(busy),      32'(m_st == M_ADD));
    check_eq("done",      32'(done),      32'(m_st == M_SHOW));
  endtask

  // Called at posedge+1: apply inputs, take one edge, update model, compare.
  task automatic cycle(input bit clr, input bit ld, input int d);
    clear = clr;
    load  = ld;
    din   = W'(d);
    @(posedge clk);
    model_step(clr, ld, d);
    #1;
    compare_all();
  endtask

  // Called at posedge+1: assert reset mid-cycle, check the asynchronous
  // effect, hold it across one edge, then release away from the edge.
  task automatic reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    int r;
    int d;
    reset = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    din   = '0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First load right after release, then 8'h12 + 8'h34.
    cycle(1'b0, 1'b1, 8'h12);
    cycle(1'b0, 1'b1, 8'h34);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("r34_sum",   32'(sum_out),   32'h46);
    check_eq("r34_carry", 32'(carry_out), 32'h0);
    check_eq("r34_ovf",   32'(ovf_out),   32'h0);
    check_eq("r34_done",  32'(done),      32'h1);
    check_eq("r34_state", 32'(state_out), 32'h3);

    // Unsigned wrap with carry out.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b1, 8'h01);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("wrap_sum",   32'(sum_out),   32'h00);
    check_eq("wrap_carry", 32'(carry_out), 32'h1);
    check_eq("wrap_ovf",   32'(ovf_out),   32'h0);

    // Signed overflow without carry.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h7F);
    cycle(1'b0, 1'b1, 8'h01);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("ovf_sum",   32'(sum_out),   32'h80);
    check_eq("ovf_carry", 32'(carry_out), 32'h0);
    check_eq("ovf_ovf",   32'(ovf_out),   32'h1);

    // A load strobe during ADD must be ignored.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h21);
    cycle(1'b0, 1'b1, 8'h13);
    cycle(1'b0, 1'b1, 8'hAA);
    check_eq("addld_a",     32'(a_out),     32'h21);
    check_eq("addld_b",     32'(b_out),     32'h13);
    check_eq("addld_sum",   32'(sum_out),   32'h34);
    check_eq("addld_state", 32'(state_out), 32'h3);

    // clear and load together in GOT_A: clear wins.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h55);
    cycle(1'b1, 1'b1, 8'h01);
    check_eq("clr_state", 32'(state_out), 32'h0);
    check_eq("clr_a",     32'(a_out),     32'h0);

    // Reset in the middle of ADD, then a normal addition.
    cycle(1'b0, 1'b1, 8'h09);
    cycle(1'b0, 1'b1, 8'h0A);
    check_eq("pre_rst_busy", 32'(busy), 32'h1);
    reset_pulse();
    check_eq("rst_sum", 32'(sum_out), 32'h0);
    cycle(1'b0, 1'b1, 8'h03);
    cycle(1'b0, 1'b1, 8'h04);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("rst_after_sum", 32'(sum_out), 32'h07);

    // A load in SHOW: accumulate in one build, fresh pair in the other.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h10);
    cycle(1'b0, 1'b1, 8'h20);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("show_sum", 32'(sum_out), 32'h30);
    cycle(1'b0, 1'b1, 8'h05);
`ifdef ADD_SEQUENCER_ACCUM_EN
    check_eq("acc_state", 32'(state_out), 32'h2);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("acc_sum",   32'(sum_out),   32'h35);
    check_eq("acc_state2", 32'(state_out), 32'h3);
`else
    check_eq("fresh_state", 32'(state_out), 32'h1);
    check_eq("fresh_a",     32'(a_out),     32'h05);
    check_eq("fresh_sum",   32'(sum_out),   32'h30);
`endif

    // Randomized traffic, biased toward arithmetic corner operands.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 5))
        0:       d = 8'hFF;
        1:       d = 8'h80;
        2:       d = 8'h7F;
        default: d = int'($urandom_range(0, MOD - 1));
      endcase
      if (r < 2) begin
        reset_pulse();
      end else if (r < 6) begin
        cycle(1'b1, ($urandom_range(0, 1) == 1), d);
      end else begin
        cycle(1'b0, ($urandom_range(0, 99) < 55), d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
